// File: rtl/pong_pkg.sv
`default_nettype none
// ============================================================================
// pong_pkg : shared types and default geometry for the pong game datapath
// Revision : 1.0
// ============================================================================
package pong_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SERVE = 3'd1,
    ST_PLAY  = 3'd2,
    ST_MISS  = 3'd3,
    ST_OVER  = 3'd4
  } state_t;

  typedef struct packed {
    logic [3:0] tens;
    logic [3:0] ones;
  } bcd_score_t;

  localparam int unsigned c_MISS_Y      = 464;
  localparam int unsigned c_SERVE_X     = 312;
  localparam int unsigned c_SERVE_Y     = 96;
  localparam int unsigned c_LIVES       = 3;
  localparam int unsigned c_MISS_FRAMES = 60;

endpackage
`default_nettype wire

// File: rtl/pong_btn_edge.sv
`default_nettype none
// ============================================================================
// pong_btn_edge : 2-flop synchronizer with a one-cycle rising-edge pulse
// Revision      : 1.0
// ============================================================================
module pong_btn_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic i_btn,
  output logic o_rise
);

  logic [1:0] r_sync;
  logic       r_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= 2'b00;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], i_btn};
      r_prev <= r_sync[1];
    end
  end

  assign o_rise = r_sync[1] & ~r_prev;

endmodule
`default_nettype wire

// File: rtl/pong_game_ctrl.sv
`default_nettype none
// ============================================================================
// pong_game_ctrl : match sequencer (idle/serve/play/miss/over), BCD score, lives
// Optional PONG_SPEEDUP_EN : ball_step rises every SPEEDUP_HITS paddle hits
// Revision       : 1.0
// ============================================================================
module pong_game_ctrl
  import pong_pkg::*;
#(
  parameter int unsigned MISS_Y      = c_MISS_Y,
  parameter int unsigned SERVE_X     = c_SERVE_X,
  parameter int unsigned SERVE_Y     = c_SERVE_Y,
  parameter int unsigned LIVES       = c_LIVES,
  parameter int unsigned MISS_FRAMES = c_MISS_FRAMES
`ifdef PONG_SPEEDUP_EN
  ,
  parameter int unsigned SPEEDUP_HITS = 8
`endif
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_frame_tick,
  input  logic       i_serve_btn,
  input  logic [8:0] i_ball_y,
  input  logic       i_paddle_hit,
  output logic       o_ball_run,
  output logic       o_ball_load,
  output logic [9:0] o_load_x,
  output logic [8:0] o_load_y,
  output logic [1:0] o_ball_step,
  output logic [7:0] o_score,
  output logic [1:0] o_lives,
  output logic       o_game_over,
  output logic [2:0] o_state
);

  localparam logic [8:0] c_MISS_Y9     = 9'(MISS_Y);
  localparam logic [7:0] c_FRAMES_LAST = 8'(MISS_FRAMES - 1);

  function automatic bcd_score_t bcd_inc(input bcd_score_t s);
    bcd_score_t r;
    r = s;
    if (s.tens == 4'd9 && s.ones == 4'd9) begin
      r = s;
    end else if (s.ones == 4'd9) begin
      r.ones = 4'd0;
      r.tens = s.tens + 4'd1;
    end else begin
      r.ones = s.ones + 4'd1;
    end
    return r;
  endfunction

  state_t     r_state;
  state_t     w_state_nxt;
  logic       w_serve;
  logic       w_miss;
  logic       w_start;
  logic       w_load;
  bcd_score_t r_score;
  logic [1:0] r_lives;
  logic [7:0] r_frame_cnt;
  logic       r_ball_run;
  logic       r_ball_load;
  logic       r_game_over;

  pong_btn_edge u_serve_edge (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_btn  (i_serve_btn),
    .o_rise (w_serve)
  );

  assign w_miss = i_frame_tick && (i_ball_y >= c_MISS_Y9);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    case (r_state)
      ST_IDLE, ST_OVER: begin
        if (w_serve) begin
          w_state_nxt = ST_SERVE;
          w_start     = 1'b1;
        end
      end
      ST_SERVE: if (w_serve) w_state_nxt = ST_PLAY;
      ST_PLAY:  if (w_miss)  w_state_nxt = ST_MISS;
      ST_MISS: begin
        if (i_frame_tick && r_frame_cnt == c_FRAMES_LAST) begin
          w_state_nxt = (r_lives == 2'd0) ? ST_OVER : ST_SERVE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    w_load = (w_state_nxt == ST_SERVE) && (r_state != ST_SERVE);
  end

  // Outputs are registered from the next state so they align with state_o.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ball_run  <= 1'b0;
      r_ball_load <= 1'b0;
      r_game_over <= 1'b0;
      r_score     <= '0;
      r_lives     <= 2'd0;
      r_frame_cnt <= 8'd0;
    end else begin
      r_ball_run  <= (w_state_nxt == ST_PLAY);
      r_ball_load <= w_load;
      r_game_over <= (w_state_nxt == ST_OVER);
      if (w_start) begin
        r_score <= '0;
        r_lives <= 2'(LIVES);
      end else if (r_state == ST_PLAY) begin
        if (i_paddle_hit) r_score <= bcd_inc(r_score);
        if (w_miss)       r_lives <= r_lives - 2'd1;
      end
      if (r_state == ST_PLAY && w_miss) begin
        r_frame_cnt <= 8'd0;
      end else if (r_state == ST_MISS && i_frame_tick) begin
        r_frame_cnt <= r_frame_cnt + 8'd1;
      end
    end
  end

`ifdef PONG_SPEEDUP_EN
  localparam logic [3:0] c_HITS_LAST = 4'(SPEEDUP_HITS - 1);

  logic [3:0] r_hit_cnt;
  logic [1:0] r_ball_step;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hit_cnt   <= 4'd0;
      r_ball_step <= 2'd1;
    end else if (w_load) begin
      r_hit_cnt   <= 4'd0;
      r_ball_step <= 2'd1;
    end else if (r_state == ST_PLAY && i_paddle_hit) begin
      if (r_hit_cnt == c_HITS_LAST) begin
        r_hit_cnt <= 4'd0;
        if (r_ball_step != 2'd3) r_ball_step <= r_ball_step + 2'd1;
      end else begin
        r_hit_cnt <= r_hit_cnt + 4'd1;
      end
    end
  end

  assign o_ball_step = r_ball_step;
`else
  assign o_ball_step = 2'd1;
`endif

  assign o_ball_run  = r_ball_run;
  assign o_ball_load = r_ball_load;
  assign o_load_x    = 10'(SERVE_X);
  assign o_load_y    = 9'(SERVE_Y);
  assign o_score     = r_score;
  assign o_lives     = r_lives;
  assign o_game_over = r_game_over;
  assign o_state     = r_state;

endmodule
`default_nettype wire

// File: tb/tb_pong_game_ctrl.sv
`default_nettype none
// ============================================================================
// tb_pong_game_ctrl : randomized scoreboard bench for pong_game_ctrl
// Revision          : 1.0
// ============================================================================
module tb_pong_game_ctrl;

  localparam int T_LIVES  = 3;
  localparam int T_FRAMES = 60;
  localparam int T_MISS_Y = 464;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ft = 1'b0;
  logic       btn = 1'b0;
  logic       ph = 1'b0;
  logic [8:0] by = 9'd0;

  logic       o_ball_run, o_ball_load, o_game_over;
  logic [9:0] o_load_x;
  logic [8:0] o_load_y;
  logic [1:0] o_ball_step, o_lives;
  logic [7:0] o_score;
  logic [2:0] o_state;

  pong_game_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_frame_tick (ft),
    .i_serve_btn  (btn),
    .i_ball_y     (by),
    .i_paddle_hit (ph),
    .o_ball_run   (o_ball_run),
    .o_ball_load  (o_ball_load),
    .o_load_x     (o_load_x),
    .o_load_y     (o_load_y),
    .o_ball_step  (o_ball_step),
    .o_score      (o_score),
    .o_lives      (o_lives),
    .o_game_over  (o_game_over),
    .o_state      (o_state)
  );

  always #5 clk = ~clk;

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  typedef struct {
    int tag;
    int st;
    int run;
    int load;
    int over;
    int step;
    int score;
    int lives;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: decimal score, tick counter, plain history of button samples.
  int m_st, m_score, m_lives, m_ticks, m_step, m_hits, m_load;
  bit m_b1, m_b2, m_b3;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_st = 0; m_score = 0; m_lives = 0; m_ticks = 0;
    m_step = 1; m_hits = 0; m_load = 0;
    m_b1 = 0; m_b2 = 0; m_b3 = 0;
  endfunction

  function automatic void model_step(input bit f, input bit p, input int y, input bit b);
    bit srv;
    int old;
    srv = m_b2 & ~m_b3;
    old = m_st;
    m_b3 = m_b2; m_b2 = m_b1; m_b1 = b;
    case (m_st)
      0, 4: if (srv) begin m_score = 0; m_lives = T_LIVES; m_st = 1; end
      1: if (srv) m_st = 2;
      2: begin
        if (p) begin
          if (m_score < 99) m_score++;
`ifdef PONG_SPEEDUP_EN
          m_hits++;
          if (m_hits == 8) begin
            m_hits = 0;
            if (m_step < 3) m_step++;
          end
`endif
        end
        if (f && y >= T_MISS_Y) begin m_lives--; m_ticks = 0; m_st = 3; end
      end
      3: if (f) begin
        m_ticks++;
        if (m_ticks == T_FRAMES) m_st = (m_lives == 0) ? 4 : 1;
      end
      default: m_st = 0;
    endcase
    m_load = (old != 1 && m_st == 1) ? 1 : 0;
    if (m_load != 0) begin m_step = 1; m_hits = 0; end
  endfunction

  function automatic exp_t snap(input int tag);
    exp_t e;
    e.tag = tag; e.st = m_st; e.run = (m_st == 2) ? 1 : 0;
    e.load = m_load; e.over = (m_st == 4) ? 1 : 0; e.step = m_step;
    e.score = (m_score / 10) * 16 + (m_score % 10); e.lives = m_lives;
    return e;
  endfunction

  task automatic step(input bit f, input bit p, input int y, input bit b, input bit r);
    @(posedge clk);
    #2;
    ft = f; ph = p; by = 9'(y); btn = b; rst_n = r;
    if (r) model_step(f, p, y, b);
    else   model_reset();
    q.push_back(snap(edge_cnt + 1));
  endtask

  task automatic press_serve();
    repeat (4) step(0, 0, 0, 1, 1);
    repeat (3) step(0, 0, 0, 0, 1);
  endtask

  bit btn_r = 0;
  task automatic rand_step();
    int r;
    int y;
    if ($urandom_range(0, 7) == 0) btn_r = ~btn_r;
    r = $urandom_range(0, 9);
    y = (r == 0) ? T_MISS_Y + $urandom_range(0, 47) :
        (r == 1) ? T_MISS_Y - 1 : (r == 2) ? T_MISS_Y : $urandom_range(0, T_MISS_Y - 2);
    step($urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0, y, btn_r, 1);
  endtask

  // Async reset: assert between edges, check outputs at once, retarget the pending entry.
  task automatic reset_now();
    exp_t e;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_run", int'(o_ball_run), 0);
    chk("async_load", int'(o_ball_load), 0);
    chk("async_step", int'(o_ball_step), 1);
    chk("async_score", int'(o_score), 0);
    chk("async_lives", int'(o_lives), 0);
    chk("async_over", int'(o_game_over), 0);
    chk("async_state", int'(o_state), 0);
    model_reset();
    if (q.size() > 0) begin
      e = q.pop_back();
      q.push_back(snap(e.tag));
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0 && q[0].tag == edge_cnt) begin
        e = q.pop_front();
        chk("state", int'(o_state), e.st);
        chk("ball_run", int'(o_ball_run), e.run);
        chk("ball_load", int'(o_ball_load), e.load);
        chk("game_over", int'(o_game_over), e.over);
        chk("ball_step", int'(o_ball_step), e.step);
        chk("score", int'(o_score), e.score);
        chk("lives", int'(o_lives), e.lives);
        chk("load_x", int'(o_load_x), 312);
        chk("load_y", int'(o_load_y), 96);
      end
    end
  end

  initial begin : driver
    int guard;
    model_reset();
    repeat (3) step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    press_serve();
    press_serve();
    for (int i = 0; i < 12; i++) step(0, 1, 0, 0, 1);
    step(1, 1, T_MISS_Y, 0, 1);
    guard = 0;
    while (m_st != 1 && guard < 400) begin
      step(guard % 2 == 0, 1, $urandom_range(0, 511), 0, 1);
      guard++;
    end
    if (m_st != 1) chk("reach_serve", m_st, 1);
    press_serve();
    for (int i = 0; i < 100; i++)
      step(i % 5 == 0, 1, (i % 2 == 1) ? T_MISS_Y - 1 : $urandom_range(0, T_MISS_Y - 2), 0, 1);
    for (int i = 0; i < 6000; i++) rand_step();
    guard = 0;
    while (m_st != 2 && guard < 3000) begin
      rand_step();
      guard++;
    end
    if (m_st != 2) chk("reach_play", m_st, 2);
    else begin
      step(0, 0, 0, btn_r, 1);
      reset_now();
    end
    repeat (3) step(0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    press_serve();
    for (int i = 0; i < 10; i++) step(0, 1, 0, 0, 1);
    repeat (3) @(posedge clk);
    if (q.size() != 0) chk("queue_drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
